// File: rtl/tmboc_trk_pkg.sv
// Shared definitions for the TMBOC tracking correlator: default widths,
// FSM encoding and the saturating adder used by every accumulator arm.
package tmboc_trk_pkg;

    localparam int PRN_LEN     = 4092;
    localparam int IN_WIDTH_D  = 4;
    localparam int ACC_WIDTH_D = 24;
    localparam int CNT_WIDTH_D = 20;
    localparam int SPACING_D   = 2;
    localparam int SAT_W       = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_INTEG = 1'b1
    } trk_state_e;

    // Operands arrive sign-extended to SAT_W; the result is clamped to the
    // signed range of a w-bit accumulator so the caller can simply truncate.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/corr_arm_acc.sv
// One correlator arm: I/Q accumulator pair fed by the sample times a +/-1
// replica chip, with saturation, synchronous clear and period-start load.
module corr_arm_acc
    import tmboc_trk_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_D,
    parameter int ACC_WIDTH = ACC_WIDTH_D
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [IN_WIDTH-1:0]  smp_i,
    input  logic signed [IN_WIDTH-1:0]  smp_q,
    input  logic                        neg,
    input  logic                        clr,
    input  logic                        load,
    input  logic                        add,
    output logic signed [ACC_WIDTH-1:0] acc_i,
    output logic signed [ACC_WIDTH-1:0] acc_q
);

    logic signed [ACC_WIDTH-1:0] ext_i, ext_q;
    logic signed [ACC_WIDTH-1:0] prod_i, prod_q;
    logic signed [ACC_WIDTH-1:0] sum_i, sum_q;

    // Widen before negating so the most negative sample has a positive image.
    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        ext_i  = ACC_WIDTH'(smp_i);
        ext_q  = ACC_WIDTH'(smp_q);
        prod_i = neg ? -ext_i : ext_i;
        prod_q = neg ? -ext_q : ext_q;
        sum_i  = ACC_WIDTH'(sat_add(SAT_W'(acc_i), SAT_W'(prod_i), ACC_WIDTH));
        sum_q  = ACC_WIDTH'(sat_add(SAT_W'(acc_q), SAT_W'(prod_q), ACC_WIDTH));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i <= '0;
            acc_q <= '0;
        end else if (clr) begin
            acc_i <= '0;
            acc_q <= '0;
        end else if (load) begin
            acc_i <= prod_i;
            acc_q <= prod_q;
        end else if (add) begin
            acc_i <= sum_i;
            acc_q <= sum_q;
        end
    end

endmodule

// File: rtl/tmboc_corr_acc.sv
// TMBOC early/prompt/late correlator: one delay line builds the replicas,
// three arms integrate one code period, results leave via valid/ready.
module tmboc_corr_acc
    import tmboc_trk_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_D,
    parameter int ACC_WIDTH = ACC_WIDTH_D,
    parameter int CNT_WIDTH = CNT_WIDTH_D,
    parameter int SPACING   = SPACING_D
) (
    input  logic                        rx_clk,
    input  logic                        rx_rst,
    input  logic                        rx_trk_en,
    input  logic signed [IN_WIDTH-1:0]  rx_bb_i,
    input  logic signed [IN_WIDTH-1:0]  rx_bb_q,
    input  logic                        rx_loc_code,
    input  logic                        rx_prn_sop,
    input  logic                        rx_prn_eop,
    input  logic                        rx_dump_ready,
    input  logic                        rx_ovf_clr,
    output logic                        tx_dump_valid,
    output logic signed [ACC_WIDTH-1:0] tx_ie,
    output logic signed [ACC_WIDTH-1:0] tx_qe,
    output logic signed [ACC_WIDTH-1:0] tx_ip,
    output logic signed [ACC_WIDTH-1:0] tx_qp,
    output logic signed [ACC_WIDTH-1:0] tx_il,
    output logic signed [ACC_WIDTH-1:0] tx_ql,
    output logic [CNT_WIDTH-1:0]        tx_dump_cnt,
    output logic                        tx_slip,
    output logic                        tx_ovf
);

    logic [2*SPACING:0]          code_sr;
    logic [SPACING:0]            sop_sr, eop_sr;
    logic signed [IN_WIDTH-1:0]  i_sr [SPACING+1];
    logic signed [IN_WIDTH-1:0]  q_sr [SPACING+1];

    // NOTE: the delay line is reset like any other state so taps never start as X.
    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            code_sr <= '0;
            sop_sr  <= '0;
            eop_sr  <= '0;
            for (int k = 0; k <= SPACING; k++) begin
                i_sr[k] <= '0;
                q_sr[k] <= '0;
            end
        end else begin
            code_sr <= {code_sr[2*SPACING-1:0], rx_loc_code};
            sop_sr  <= {sop_sr[SPACING-1:0], rx_prn_sop};
            eop_sr  <= {eop_sr[SPACING-1:0], rx_prn_eop};
            i_sr[0] <= rx_bb_i;
            q_sr[0] <= rx_bb_q;
            for (int k = 1; k <= SPACING; k++) begin
                i_sr[k] <= i_sr[k-1];
                q_sr[k] <= q_sr[k-1];
            end
        end
    end

    logic sop_a, eop_a;
    assign sop_a = sop_sr[SPACING];
    assign eop_a = eop_sr[SPACING];

    trk_state_e           state, state_n;
    logic                 eop_seen, eop_seen_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic                 close, arm_clr, arm_load, arm_add;
    logic                 dump_fire, ovf_set, slip_n;

    always_comb begin
        state_n    = state;
        eop_seen_n = eop_seen;
        cnt_n      = cnt;
        close      = 1'b0;
        arm_clr    = 1'b0;
        arm_load   = 1'b0;
        arm_add    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sop_a && rx_trk_en) begin
                    arm_load   = 1'b1;
                    cnt_n      = CNT_WIDTH'(1);
                    eop_seen_n = eop_a;
                    state_n    = ST_INTEG;
                end else begin
                    arm_clr = 1'b1;
                end
            end
            ST_INTEG: begin
                if (!rx_trk_en) begin
                    arm_clr    = 1'b1;
                    cnt_n      = '0;
                    eop_seen_n = 1'b0;
                    state_n    = ST_IDLE;
                end else if (sop_a) begin
                    // A coincident eop belongs to the period that starts here.
                    close      = 1'b1;
                    arm_load   = 1'b1;
                    cnt_n      = CNT_WIDTH'(1);
                    eop_seen_n = eop_a;
                end else begin
                    arm_add = 1'b1;
                    cnt_n   = (&cnt) ? cnt : cnt + 1'b1;
                    if (eop_a) begin
                        eop_seen_n = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign dump_fire = close && eop_seen && (!tx_dump_valid || rx_dump_ready);
    assign ovf_set   = close && eop_seen && tx_dump_valid && !rx_dump_ready;
    assign slip_n    = close && !eop_seen;

    logic signed [ACC_WIDTH-1:0] e_i, e_q, p_i, p_q, l_i, l_q;

    corr_arm_acc #(.IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_early (
        .clk(rx_clk), .rst_n(rx_rst), .smp_i(i_sr[SPACING]), .smp_q(q_sr[SPACING]),
        .neg(code_sr[0]), .clr(arm_clr), .load(arm_load), .add(arm_add),
        .acc_i(e_i), .acc_q(e_q)
    );
    corr_arm_acc #(.IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_prompt (
        .clk(rx_clk), .rst_n(rx_rst), .smp_i(i_sr[SPACING]), .smp_q(q_sr[SPACING]),
        .neg(code_sr[SPACING]), .clr(arm_clr), .load(arm_load), .add(arm_add),
        .acc_i(p_i), .acc_q(p_q)
    );
    corr_arm_acc #(.IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_late (
        .clk(rx_clk), .rst_n(rx_rst), .smp_i(i_sr[SPACING]), .smp_q(q_sr[SPACING]),
        .neg(code_sr[2*SPACING]), .clr(arm_clr), .load(arm_load), .add(arm_add),
        .acc_i(l_i), .acc_q(l_q)
    );

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            state         <= ST_IDLE;
            eop_seen      <= 1'b0;
            cnt           <= '0;
            tx_dump_valid <= 1'b0;
            tx_ie         <= '0;
            tx_qe         <= '0;
            tx_ip         <= '0;
            tx_qp         <= '0;
            tx_il         <= '0;
            tx_ql         <= '0;
            tx_dump_cnt   <= '0;
            tx_slip       <= 1'b0;
            tx_ovf        <= 1'b0;
        end else begin
            state    <= state_n;
            eop_seen <= eop_seen_n;
            cnt      <= cnt_n;
            tx_slip  <= slip_n;
            tx_ovf   <= ovf_set | (tx_ovf & ~rx_ovf_clr);
            tx_dump_valid <= dump_fire | (tx_dump_valid & ~rx_dump_ready);
            if (dump_fire) begin
                tx_ie       <= e_i;
                tx_qe       <= e_q;
                tx_ip       <= p_i;
                tx_qp       <= p_q;
                tx_il       <= l_i;
                tx_ql       <= l_q;
                tx_dump_cnt <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_tmboc_corr_acc.sv
// Directed bench for tmboc_corr_acc: three instances (SPACING 2/1, ACC_WIDTH 24/8)
// share the stimulus; each test resets all of them and checks one.
module tb_tmboc_corr_acc;

    localparam int SP_T [3] = '{2, 1, 2};
    localparam int AW_T [3] = '{24, 24, 8};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic trk_en = 1'b0, code = 1'b0, sop = 1'b0, eop = 1'b0;
    logic ready = 1'b0, ovf_clr = 1'b0;
    logic signed [3:0] bb_i = '0, bb_q = '0;

    // Observed outputs per instance: ie qe ip qp il ql cnt valid slip ovf
    int obs [3][10];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic signed [AW_T[g]-1:0] ie, qe, ip, qp, il, ql;
        logic [19:0] cnt;
        logic valid, slip, ovf;

        tmboc_corr_acc #(.IN_WIDTH(4), .ACC_WIDTH(AW_T[g]), .CNT_WIDTH(20), .SPACING(SP_T[g])) dut (
            .rx_clk(clk), .rx_rst(rst), .rx_trk_en(trk_en),
            .rx_bb_i(bb_i), .rx_bb_q(bb_q), .rx_loc_code(code),
            .rx_prn_sop(sop), .rx_prn_eop(eop),
            .rx_dump_ready(ready), .rx_ovf_clr(ovf_clr),
            .tx_dump_valid(valid),
            .tx_ie(ie), .tx_qe(qe), .tx_ip(ip), .tx_qp(qp), .tx_il(il), .tx_ql(ql),
            .tx_dump_cnt(cnt), .tx_slip(slip), .tx_ovf(ovf)
        );

        assign obs[g][0] = int'(ie);
        assign obs[g][1] = int'(qe);
        assign obs[g][2] = int'(ip);
        assign obs[g][3] = int'(qp);
        assign obs[g][4] = int'(il);
        assign obs[g][5] = int'(ql);
        assign obs[g][6] = int'(cnt);
        assign obs[g][7] = int'(valid);
        assign obs[g][8] = int'(slip);
        assign obs[g][9] = int'(ovf);
    end

    localparam int O_IP = 2, O_CNT = 6, O_VALID = 7, O_SLIP = 8, O_OVF = 9;

    typedef struct {
        int dut;
        int code_mode;   // 0: constant 0, 1: constant 1, 2: 0011 repeating
        int i_v;
        int q_v;
        int per;
        int exp [7];
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Stimulus configuration read by drive()
    int s0, per, nsop, code_mode, i_a, i_b, i_sw, q_v;
    bit skip_eop [4];

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic code_at(input int n);
        case (code_mode)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return (n % 4) >= 2;
        endcase
    endfunction

    // Inputs for cycle n; they are sampled by the next rising edge.
    task automatic drive(input int n);
        code = code_at(n);
        sop  = 1'b0;
        eop  = 1'b0;
        for (int k = 0; k < nsop; k++) begin
            if (n == s0 + k * per) sop = 1'b1;
            if (k > 0 && n == s0 + k * per - 10 && !skip_eop[k]) eop = 1'b1;
        end
        if (code_mode == 2) bb_i = code ? -4'sd1 : 4'sd1;
        else                bb_i = 4'(n < i_sw ? i_a : i_b);
        bb_q = 4'(q_v);
    endtask

    task automatic do_reset();
        rst = 1'b0; trk_en = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
        sop = 1'b0; eop = 1'b0; code = 1'b0; bb_i = '0; bb_q = '0;
        s0 = 5; per = 20; nsop = 2; code_mode = 0;
        i_a = 1; i_b = 1; i_sw = 1 << 20; q_v = 0;
        for (int k = 0; k < 4; k++) skip_eop[k] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    vec_t  vecs [5];
    string nm [7] = '{"ie", "qe", "ip", "qp", "il", "ql", "cnt"};

    initial begin
        vecs[0] = '{0, 0,  3, -1, 100, '{300, -100, 300, -100, 300, -100, 100}};
        vecs[1] = '{0, 1, -2,  5,  50, '{100, -250, 100, -250, 100, -250, 50}};
        vecs[2] = '{2, 0, -8,  7, 100, '{-128, 127, -128, 127, -128, 127, 100}};
        vecs[3] = '{2, 1, -8,  0, 100, '{127, 0, 127, 0, 127, 0, 100}};
        vecs[4] = '{1, 2,  0,  1, 400, '{0, 0, 400, 0, 0, 0, 400}};

        // Reset state
        do_reset();
        for (int k = 0; k < 10; k++) check($sformatf("reset_o%0d", k), obs[0][k], 0);

        // Main function: one full period, dump one clock after the closing sop_a
        for (int v = 0; v < 5; v++) begin
            int d, sp;
            do_reset();
            d = vecs[v].dut;
            sp = SP_T[d];
            per = vecs[v].per; code_mode = vecs[v].code_mode;
            i_a = vecs[v].i_v; i_b = vecs[v].i_v; q_v = vecs[v].q_v;
            trk_en = 1'b1; ready = 1'b1;
            for (int n = 0; n <= s0 + per + sp + 1; n++) begin
                drive(n);
                tick();
                if (n == s0 + per + sp)
                    check($sformatf("v%0d_valid_early", v), obs[d][O_VALID], 0);
                if (n == s0 + per + sp + 1) begin
                    check($sformatf("v%0d_valid", v), obs[d][O_VALID], 1);
                    for (int k = 0; k < 7; k++)
                        check($sformatf("v%0d_%s", v, nm[k]), obs[d][k], vecs[v].exp[k]);
                end
            end
        end

        // Overflow: consumer stalls across two closes, clear races with set
        do_reset();
        nsop = 3; i_a = 1; i_b = 2; i_sw = 25;
        trk_en = 1'b1;
        for (int n = 0; n <= 62; n++) begin
            ovf_clr = (n == 48) || (n == 55);
            ready   = (n == 60);
            drive(n);
            tick();
            if (n == 28) check("ovf_first_dump_ip", obs[0][O_IP], 20);
            if (n == 48) begin
                check("ovf_set_wins", obs[0][O_OVF], 1);
                check("ovf_valid_held", obs[0][O_VALID], 1);
                check("ovf_ip_held", obs[0][O_IP], 20);
                check("ovf_cnt_held", obs[0][O_CNT], 20);
            end
            if (n == 54) check("ovf_sticky", obs[0][O_OVF], 1);
            if (n == 55) check("ovf_cleared", obs[0][O_OVF], 0);
            if (n == 59) check("hs_valid_before_ready", obs[0][O_VALID], 1);
            if (n == 60) check("hs_valid_drops", obs[0][O_VALID], 0);
        end

        // Slip: no eop in the first period
        do_reset();
        nsop = 3; i_a = 1; i_b = 3; i_sw = 25; skip_eop[1] = 1'b1;
        trk_en = 1'b1; ready = 1'b1;
        for (int n = 0; n <= 48; n++) begin
            drive(n);
            tick();
            if (n == 27) check("slip_before", obs[0][O_SLIP], 0);
            if (n == 28) begin
                check("slip_pulse", obs[0][O_SLIP], 1);
                check("slip_no_valid", obs[0][O_VALID], 0);
            end
            if (n == 29) check("slip_one_clock", obs[0][O_SLIP], 0);
            if (n == 47) check("slip_next_valid_early", obs[0][O_VALID], 0);
            if (n == 48) begin
                check("slip_next_valid", obs[0][O_VALID], 1);
                check("slip_next_ip", obs[0][O_IP], 60);
                check("slip_next_cnt", obs[0][O_CNT], 20);
            end
        end

        // Asynchronous reset in the middle of a period with a dump pending
        do_reset();
        trk_en = 1'b1;
        for (int n = 0; n <= 35; n++) begin
            drive(n);
            tick();
            if (n == 28) check("arst_pre_ip", obs[0][O_IP], 20);
        end
        #3 rst = 1'b0;
        #1;
        check("arst_valid", obs[0][O_VALID], 0);
        check("arst_ip", obs[0][O_IP], 0);
        check("arst_ie", obs[0][0], 0);
        check("arst_cnt", obs[0][O_CNT], 0);
        rst = 1'b1;

        // Tracking disabled mid-period: no dump, resume on the next sop_a
        do_reset();
        nsop = 3; i_a = 1; i_b = 2; i_sw = 25;
        ready = 1'b1;
        for (int n = 0; n <= 48; n++) begin
            trk_en = !(n >= 15 && n < 18);
            drive(n);
            tick();
            if (n == 28) begin
                check("trk_no_dump", obs[0][O_VALID], 0);
                check("trk_no_slip", obs[0][O_SLIP], 0);
            end
            if (n == 48) begin
                check("trk_resume_valid", obs[0][O_VALID], 1);
                check("trk_resume_ip", obs[0][O_IP], 40);
                check("trk_resume_cnt", obs[0][O_CNT], 20);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
